// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite MMIO slave: response codes, FSM states and
// the address-to-register-index helper.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    WR_COLLECT = 1'b0,
    WR_RESP    = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  // Number of byte-offset bits below the register index.
  function automatic int addr_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite port bundle. Handshake rule on every channel: a beat transfers on
// a rising ACLK edge where valid && ready; valid, once raised, holds its payload until then.
interface axi_lite_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_hold.sv
// Single-entry capture buffer: takes one beat when empty and not blocked,
// and holds it until clr empties it.
module axi_lite_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         block,
  input  logic         clr,
  output logic         full,
  output logic [W-1:0] data
);

  assign in_ready = !full && !block;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (in_valid && in_ready) begin
      full <= 1'b1;
      data <= in_data;
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite slave register file: RW control registers with byte strobes,
// RO status registers fed from hw_status, SLVERR on bad index or RO write.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int                         ADDR_W    = 8,
  parameter int                         DATA_W    = 32,
  parameter int                         NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0]        RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  axi_lite_if.slave                    bus,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  output logic [NUM_REGS-1:0]          wr_pulse,
  output logic [NUM_REGS-1:0]          rd_pulse
);

  localparam int ADDR_LSB = addr_lsb(DATA_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;
  localparam int STRB_W   = DATA_W / 8;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                         aw_full, w_full, commit;
  logic [ADDR_W-1:0]            aw_addr_q;
  logic [DATA_W-1:0]            w_data_q;
  logic [STRB_W-1:0]            w_strb_q;
  logic [NUM_REGS-1:0]          aw_sel, ar_sel;
  logic                         aw_ok, ar_hit, ar_hs;
  logic [DATA_W-1:0]            rd_word;
  logic [NUM_REGS*DATA_W-1:0]   reg_r;

  assign bus.bvalid  = (wr_state == WR_RESP);
  assign bus.rvalid  = (rd_state == RD_RESP);
  assign bus.arready = (rd_state == RD_IDLE);
  assign ar_hs       = bus.arvalid && bus.arready;
  assign reg_q       = reg_r;

  // Both hold buffers are blocked while a write response is outstanding.
  axi_lite_hold #(.W(ADDR_W)) u_aw_hold (
    .clk(ACLK), .rst(ARESET),
    .in_valid(bus.awvalid), .in_ready(bus.awready), .in_data(bus.awaddr),
    .block(bus.bvalid), .clr(commit),
    .full(aw_full), .data(aw_addr_q)
  );

  axi_lite_hold #(.W(DATA_W + STRB_W)) u_w_hold (
    .clk(ACLK), .rst(ARESET),
    .in_valid(bus.wvalid), .in_ready(bus.wready), .in_data({bus.wdata, bus.wstrb}),
    .block(bus.bvalid), .clr(commit),
    .full(w_full), .data({w_data_q, w_strb_q})
  );

  // One-hot decode; an index past NUM_REGS selects nothing and so errors.
  always_comb begin
    aw_sel  = '0;
    ar_sel  = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      aw_sel[i] = (aw_addr_q[ADDR_W-1:ADDR_LSB] == IDX_W'(i));
      ar_sel[i] = (bus.araddr[ADDR_W-1:ADDR_LSB] == IDX_W'(i));
      if (ar_sel[i])
        rd_word = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : reg_r[i*DATA_W +: DATA_W];
    end
  end

  assign aw_ok  = |(aw_sel & ~RO_MASK);
  assign ar_hit = |ar_sel;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state <= WR_COLLECT;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    commit  = 1'b0;
    case (wr_state)
      WR_COLLECT: if (aw_full && w_full) begin
        commit  = 1'b1;
        wr_next = WR_RESP;
      end
      WR_RESP: if (bus.bready) wr_next = WR_COLLECT;
      default: wr_next = WR_COLLECT;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (bus.arvalid) rd_next = RD_RESP;
      RD_RESP: if (bus.rready)  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      reg_r     <= RESET_VAL;
      wr_pulse  <= '0;
      bus.bresp <= OKAY;
    end else begin
      wr_pulse <= commit ? (aw_sel & ~RO_MASK) : '0;
      if (commit) begin
        bus.bresp <= aw_ok ? OKAY : SLVERR;
        for (int i = 0; i < NUM_REGS; i++)
          for (int b = 0; b < STRB_W; b++)
            if (aw_sel[i] && !RO_MASK[i] && w_strb_q[b])
              reg_r[i*DATA_W + b*8 +: 8] <= w_data_q[b*8 +: 8];
      end
    end
  end

  // Sampling reg_r here gives a same-edge read the pre-write value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      bus.rdata <= '0;
      bus.rresp <= OKAY;
      rd_pulse  <= '0;
    end else begin
      rd_pulse <= ar_hs ? ar_sel : '0;
      if (ar_hs) begin
        bus.rdata <= rd_word;
        bus.rresp <= ar_hit ? OKAY : SLVERR;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bus.awprot, bus.arprot, aw_addr_q[ADDR_LSB-1:0], bus.araddr[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Bench for axi_lite_regfile: directed vector table, hand sequences for
// same-edge read/write and reset under response, then randomized traffic.
module tb_axi_lite_regfile;

  localparam int NR = 16;
  localparam logic [NR-1:0] RO = 16'hF000;

  function automatic logic [NR*32-1:0] mk_reset();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++)
      v[i*32 +: 32] = (i == 2) ? 32'hA5A5_0000 : 32'h0101_0101 * i;
    return v;
  endfunction

  localparam logic [NR*32-1:0] RST_V = mk_reset();

  logic ACLK, ARESET;
  logic [NR*32-1:0] reg_q, hw_status;
  logic [NR-1:0]    wr_pulse, rd_pulse;

  axi_lite_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  axi_lite_regfile #(
    .ADDR_W(8), .DATA_W(32), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RST_V)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .bus(bus), .reg_q(reg_q),
    .hw_status(hw_status), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_regs [NR];

  task automatic check(input string nm, input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = RST_V[i*32 +: 32];
  endtask

  function automatic logic [NR*32-1:0] model_flat();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[i*32 +: 32] = m_regs[i];
    return v;
  endfunction

  function automatic bit model_wr_ok(input logic [7:0] a);
    int idx;
    idx = int'(a) / 4;
    return (idx < NR) && !RO[idx];
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int idx;
    idx = int'(a) / 4;
    if (idx >= NR) return 32'h0;
    return RO[idx] ? hw_status[idx*32 +: 32] : m_regs[idx];
  endfunction

  task automatic send_aw(input logic [7:0] a, input int dly);
    int cnt;
    repeat (dly) begin @(posedge ACLK); #1; end
    bus.awaddr = a; bus.awvalid = 1'b1;
    cnt = 0;
    while (!bus.awready && cnt < 20) begin @(posedge ACLK); #1; cnt++; end
    if (cnt >= 20) check("aw_timeout", 1, 0);
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int cnt;
    repeat (dly) begin @(posedge ACLK); #1; end
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    cnt = 0;
    while (!bus.wready && cnt < 20) begin @(posedge ACLK); #1; cnt++; end
    if (cnt >= 20) check("w_timeout", 1, 0);
    @(posedge ACLK); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] exp_resp);
    logic [NR-1:0] exp_pulse;
    int idx;
    idx = int'(a) / 4;
    exp_pulse = '0;
    if (model_wr_ok(a)) begin
      exp_pulse[idx] = 1'b1;
      for (int b = 0; b < 4; b++)
        if (s[b]) m_regs[idx][b*8 +: 8] = d[b*8 +: 8];
    end
    fork
      send_aw(a, aw_dly);
      send_w(d, s, w_dly);
    join
    @(posedge ACLK); #1;
    check("bvalid_latency", bus.bvalid, 1'b1);
    check("bresp", bus.bresp, exp_resp);
    check("wr_pulse", wr_pulse, exp_pulse);
    check("reg_q_after_wr", reg_q, model_flat());
    for (int k = 0; k < b_dly; k++) begin
      @(posedge ACLK); #1;
      check("bvalid_hold", {bus.bvalid, bus.bresp, bus.awready, bus.wready}, {1'b1, exp_resp, 2'b00});
      check("wr_pulse_once", wr_pulse, '0);
    end
    bus.bready = 1'b1;
    @(posedge ACLK); #1;
    bus.bready = 1'b0;
    check("b_done", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
    check("wr_pulse_clear", wr_pulse, '0);
  endtask

  task automatic do_read(input logic [7:0] a, input int r_dly,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [NR-1:0] exp_pulse;
    int idx, cnt;
    idx = int'(a) / 4;
    exp_pulse = '0;
    if (idx < NR) exp_pulse[idx] = 1'b1;
    bus.araddr = a; bus.arvalid = 1'b1;
    cnt = 0;
    while (!bus.arready && cnt < 20) begin @(posedge ACLK); #1; cnt++; end
    if (cnt >= 20) check("ar_timeout", 1, 0);
    @(posedge ACLK); #1;
    bus.arvalid = 1'b0;
    check("rvalid", bus.rvalid, 1'b1);
    check("rdata", bus.rdata, exp_data);
    check("rresp", bus.rresp, exp_resp);
    check("rd_pulse", rd_pulse, exp_pulse);
    for (int k = 0; k < r_dly; k++) begin
      @(posedge ACLK); #1;
      check("r_hold", {bus.rvalid, bus.arready, bus.rdata, bus.rresp}, {2'b10, exp_data, exp_resp});
      check("rd_pulse_once", rd_pulse, '0);
    end
    bus.rready = 1'b1;
    @(posedge ACLK); #1;
    bus.rready = 1'b0;
    check("r_done", {bus.rvalid, bus.arready}, 2'b01);
  endtask

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          d0;
    int          d1;
    int          d2;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] old5;
    // d0/d1 = AW/W start delays, d2 = response back-pressure cycles
    vecs[0]  = '{0, 8'h08, 32'h0,         4'h0, 0, 0, 0, 32'hA5A5_0000, 2'b00};
    vecs[1]  = '{1, 8'h04, 32'h1234_5678, 4'hF, 0, 3, 0, 32'h0,         2'b00};
    vecs[2]  = '{0, 8'h04, 32'h0,         4'h0, 0, 0, 0, 32'h1234_5678, 2'b00};
    vecs[3]  = '{1, 8'h04, 32'hFFFF_FFFF, 4'h3, 2, 0, 0, 32'h0,         2'b00};
    vecs[4]  = '{0, 8'h04, 32'h0,         4'h0, 0, 0, 0, 32'h1234_FFFF, 2'b00};
    vecs[5]  = '{1, 8'h40, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 32'h0,         2'b10};
    vecs[6]  = '{1, 8'h30, 32'hCAFE_F00D, 4'hF, 1, 0, 0, 32'h0,         2'b10};
    vecs[7]  = '{0, 8'h40, 32'h0,         4'h0, 0, 0, 0, 32'h0,         2'b10};
    vecs[8]  = '{0, 8'h30, 32'h0,         4'h0, 0, 0, 0, 32'hC0DE_000C, 2'b00};
    vecs[9]  = '{1, 8'h0B, 32'h0,         4'h0, 0, 0, 0, 32'h0,         2'b00};
    vecs[10] = '{0, 8'h0A, 32'h0,         4'h0, 0, 0, 0, 32'hA5A5_0000, 2'b00};
    vecs[11] = '{1, 8'h08, 32'hDEAD_BEEF, 4'h8, 0, 0, 5, 32'h0,         2'b00};
    vecs[12] = '{0, 8'h08, 32'h0,         4'h0, 0, 0, 4, 32'hDEA5_0000, 2'b00};

    for (int i = 0; i < NR; i++)
      hw_status[i*32 +: 32] = RO[i] ? (32'hC0DE_0000 + i) : 32'hBAD0_0000 + i;
    ARESET = 1'b1;
    bus.awvalid = 0; bus.awaddr = 0; bus.awprot = 0;
    bus.wvalid = 0;  bus.wdata = 0;  bus.wstrb = 0;  bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arprot = 0; bus.rready = 0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;

    check("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("rst_valid", {bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}, '0);
    check("rst_rdata", bus.rdata, '0);
    check("rst_reg_q", reg_q, RST_V);
    check("rst_pulses", {wr_pulse, rd_pulse}, '0);

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].is_wr)
        do_write(vecs[v].addr, vecs[v].data, vecs[v].strb,
                 vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].exp_resp);
      else
        do_read(vecs[v].addr, vecs[v].d2, vecs[v].exp_data, vecs[v].exp_resp);
    end

    // Read accepted on the write-commit edge of the same register
    old5 = m_regs[5];
    bus.awaddr = 8'h14; bus.awvalid = 1'b1;
    bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 8'h14; bus.arvalid = 1'b1;
    @(posedge ACLK); #1;
    bus.arvalid = 1'b0;
    m_regs[5] = 32'h5555_AAAA;
    check("same_edge_rdata", bus.rdata, old5);
    check("same_edge_valid", {bus.bvalid, bus.rvalid}, 2'b11);
    check("same_edge_reg_q", reg_q, model_flat());
    bus.bready = 1'b1; bus.rready = 1'b1;
    @(posedge ACLK); #1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("same_edge_done", {bus.bvalid, bus.rvalid}, 2'b00);

    // Reset while a write response is pending
    bus.awaddr = 8'h18; bus.awvalid = 1'b1;
    bus.wdata = 32'h0000_0077; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(posedge ACLK); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(posedge ACLK); #1;
    check("pre_reset_bvalid", bus.bvalid, 1'b1);
    #2 ARESET = 1'b1;
    #1;
    check("async_bvalid_drop", bus.bvalid, 1'b0);
    check("async_reg_q", reg_q, RST_V);
    repeat (2) @(posedge ACLK);
    #1 ARESET = 1'b0;
    model_reset();
    check("post_reset_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("post_reset_pulses", {wr_pulse, rd_pulse}, '0);

    // Randomized traffic against the behavioural model
    for (int i = 0; i < NR; i++)
      if (RO[i]) hw_status[i*32 +: 32] = $urandom;
    for (int t = 0; t < 40; t++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 8'h47));
      if ($urandom_range(0, 1) == 1) begin
        logic [31:0] d;
        logic [3:0]  s;
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 model_wr_ok(a) ? 2'b00 : 2'b10);
      end else begin
        do_read(a, $urandom_range(0, 2), model_read(a), (int'(a) / 4 < NR) ? 2'b00 : 2'b10);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

endmodule
